rs_encoder: RTL



---
 rtl/rs_pkg.sv | 84 ++++++++
 rtl/rs_lfsr_step.sv | 32 +++
 rtl/rs_encoder.sv | 113 +++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_pkg
//  Description : Shared constants, state encoding and GF(8) index-domain
//                arithmetic for the RS(7,3) encoder (primitive x^3+x+1).
//                Index encoding: 0 = zero, k in 1..7 = alpha^(k-1).
//  Revision    : 1.0 - initial release
// ============================================================================
package rs_pkg;

    localparam int SYM_W = 3;
    localparam int N_SYM = 7;
    localparam int K_SYM = 3;
    localparam int MSG_W = K_SYM * SYM_W;
    localparam int CW_W  = N_SYM * SYM_W;

    typedef logic [SYM_W-1:0] sym_t;

    // g(x) = x^4 + a^3 x^3 + x^2 + a x + a^3, index form
    localparam sym_t G3 = 3'd4;
    localparam sym_t G2 = 3'd1;
    localparam sym_t G1 = 3'd2;
    localparam sym_t G0 = 3'd4;

    // Controller states
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_SHIFT = 2'd1;
    localparam state_t S_DONE  = 2'd2;

    // Index -> polynomial-basis bit pattern
    function automatic sym_t idx_to_poly(input sym_t a);
        sym_t p;
        case (a)
            3'd0:    p = 3'b000;
            3'd1:    p = 3'b100;
            3'd2:    p = 3'b010;
            3'd3:    p = 3'b001;
            3'd4:    p = 3'b110;
            3'd5:    p = 3'b011;
            3'd6:    p = 3'b111;
            default: p = 3'b101;
        endcase
        return p;
    endfunction

    // Polynomial-basis bit pattern -> index
    function automatic sym_t poly_to_idx(input sym_t p);
        sym_t a;
        case (p)
            3'b000:  a = 3'd0;
            3'b100:  a = 3'd1;
            3'b010:  a = 3'd2;
            3'b001:  a = 3'd3;
            3'b110:  a = 3'd4;
            3'b011:  a = 3'd5;
            3'b111:  a = 3'd6;
            default: a = 3'd7;
        endcase
        return a;
    endfunction

    // Field addition: XOR in the polynomial basis
    function automatic sym_t gf_add(input sym_t a, input sym_t b);
        return poly_to_idx(idx_to_poly(a) ^ idx_to_poly(b));
    endfunction

    // Field multiplication: add exponents mod 7; a zero operand forces zero
    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        logic [3:0] s;
        sym_t       r;
        s = {1'b0, a} + {1'b0, b} - 4'd2;
        if (s >= 4'd7) begin
            s = s - 4'd7;
        end
        r = s[2:0] + 3'd1;
        if (a == 3'd0 || b == 3'd0) begin
            r = 3'd0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs_lfsr_step.sv
`default_nettype none
// ============================================================================
//  Module      : rs_lfsr_step
//  Description : One combinational step of the RS(7,3) parity LFSR. Given the
//                feedback symbol and the current parity registers, produces
//                the next parity register contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_lfsr_step
    import rs_pkg::*;
(
    input  logic [SYM_W-1:0] i_fb,
    input  logic [SYM_W-1:0] i_r3,
    input  logic [SYM_W-1:0] i_r2,
    input  logic [SYM_W-1:0] i_r1,
    input  logic [SYM_W-1:0] i_r0,
    output logic [SYM_W-1:0] o_r3,
    output logic [SYM_W-1:0] o_r2,
    output logic [SYM_W-1:0] o_r1,
    output logic [SYM_W-1:0] o_r0
);

    // Shift toward r3, folding the generator-weighted feedback into each tap
    always_comb begin
        o_r3 = gf_add(i_r2, gf_mul(G3, i_fb));
        o_r2 = gf_add(i_r1, gf_mul(G2, i_fb));
        o_r1 = gf_add(i_r0, gf_mul(G1, i_fb));
        o_r0 = gf_mul(G0, i_fb);
    end

endmodule
`default_nettype wire

// File: rtl/rs_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : rs_encoder
//  Description : Systematic RS(7,3) encoder over GF(8). Accepts a 3-symbol
//                message, runs it through a serial parity LFSR (m2 first,
//                one symbol per cycle) and presents {m2,m1,m0,p3..p0} with a
//                valid/ready handshake. One codeword in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_encoder
    import rs_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [MSG_W-1:0] in_msg,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW_W-1:0] out_codeword
);

    state_t            r_state;
    logic [MSG_W-1:0]  r_msg;
    logic [1:0]        r_count;
    sym_t              r_r3, r_r2, r_r1, r_r0;
    logic [CW_W-1:0]   r_codeword;

    sym_t              w_sym;
    sym_t              w_fb;
    sym_t              w_r3_nxt, w_r2_nxt, w_r1_nxt, w_r0_nxt;

    // Select the message symbol for this step, highest degree first
    always_comb begin
        case (r_count)
            2'd0:    w_sym = r_msg[8:6];
            2'd1:    w_sym = r_msg[5:3];
            default: w_sym = r_msg[2:0];
        endcase
        w_fb = gf_add(w_sym, r_r3);
    end

    rs_lfsr_step u_lfsr_step (
        .i_fb (w_fb),
        .i_r3 (r_r3),
        .i_r2 (r_r2),
        .i_r1 (r_r1),
        .i_r0 (r_r0),
        .o_r3 (w_r3_nxt),
        .o_r2 (w_r2_nxt),
        .o_r1 (w_r1_nxt),
        .o_r0 (w_r0_nxt)
    );

    // Controller, LFSR registers and output codeword register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_msg      <= '0;
            r_count    <= 2'd0;
            r_r3       <= '0;
            r_r2       <= '0;
            r_r1       <= '0;
            r_r0       <= '0;
            r_codeword <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_msg   <= in_msg;
                        r_r3    <= '0;
                        r_r2    <= '0;
                        r_r1    <= '0;
                        r_r0    <= '0;
                        r_count <= 2'd0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_r3 <= w_r3_nxt;
                    r_r2 <= w_r2_nxt;
                    r_r1 <= w_r1_nxt;
                    r_r0 <= w_r0_nxt;
                    if (r_count == 2'd2) begin
                        // Last message symbol: capture the finished codeword
                        r_count    <= 2'd0;
                        r_codeword <= {r_msg, w_r3_nxt, w_r2_nxt, w_r1_nxt, w_r0_nxt};
                        r_state    <= S_DONE;
                    end else begin
                        r_count <= r_count + 2'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode directly from state so reset clears them at once
    always_comb begin
        in_ready     = (r_state == S_IDLE);
        out_valid    = (r_state == S_DONE);
        out_codeword = r_codeword;
    end

endmodule
`default_nettype wire
